// File: rtl/rb_reader.sv
// Read-back sequencer: streams entries 0..N-1 of the synchronous result RAM out on a valid/ready port.
// Optional `RB_LAST_EN adds out_last_o, flagging the final beat of the batch.
//
// state  | meaning
// IDLE   | waiting for start_i
// READ   | issuing RAM reads while the output buffer has room
// DRAIN  | all reads issued, emptying the output buffer
// FIN    | one-cycle done pulse
module rb_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   count_i,
    output logic              mem_re_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o
`ifdef RB_LAST_EN
    ,
    output logic              out_last_o
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [ADDR_W:0] N_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   issue_q, issue_d;
    logic [ADDR_W:0]   popc_q, popc_d;
    logic [1:0]        occ_q, occ_d;
    logic              infl_q, infl_d;
    logic [DATA_W-1:0] ent0_q, ent0_d;
    logic [DATA_W-1:0] ent1_q, ent1_d;

    logic [DATA_W-1:0] e0, e1;
    logic [ADDR_W:0]   n_sat;
    logic [1:0]        tot, used;
    logic              valid, pop, re;

    // Queue order is stored entries then the read returning this cycle, so the
    // returning word can be presented immediately when nothing is stored.
    always_comb begin
        e0    = (occ_q != 2'd0) ? ent0_q : mem_rdata_i;
        e1    = (occ_q == 2'd2) ? ent1_q : mem_rdata_i;
        valid = (occ_q != 2'd0) | infl_q;
        pop   = valid & out_ready_i;
        tot   = occ_q + {1'b0, infl_q};
        used  = tot - {1'b0, pop};
        re    = (state_q == S_READ) && (used < 2'd2);
        n_sat = (count_i > N_MAX) ? N_MAX : count_i;
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        issue_d = issue_q + {{ADDR_W{1'b0}}, re};
        popc_d  = popc_q + {{ADDR_W{1'b0}}, pop};
        occ_d   = used;
        infl_d  = re;
        ent0_d  = pop ? e1 : e0;
        ent1_d  = e1;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d     = n_sat;
                    issue_d = '0;
                    popc_d  = '0;
                    state_d = (n_sat == '0) ? S_FIN : S_READ;
                end
            end
            S_READ: begin
                if (re && (issue_q + ONE == n_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && (popc_q + ONE == n_q)) begin
                    state_d = S_FIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            issue_q <= '0;
            popc_q  <= '0;
            occ_q   <= '0;
            infl_q  <= 1'b0;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            issue_q <= issue_d;
            popc_q  <= popc_d;
            occ_q   <= occ_d;
            infl_q  <= infl_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

    assign mem_re_o    = re;
    assign mem_addr_o  = (state_q == S_READ) ? issue_q[ADDR_W-1:0] : '0;
    assign out_valid_o = valid;
    assign out_data_o  = valid ? e0 : '0;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_FIN);
`ifdef RB_LAST_EN
    assign out_last_o  = valid && (popc_q + ONE == n_q);
`endif

endmodule

// File: tb/tb_rb_reader.sv
// Directed bench for rb_reader: RAM model holds 0x100+i, a monitor scoreboards every read and beat.
// Build with RB_LAST_EN defined to also exercise out_last_o.
module tb_rb_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  count = '0;
    logic        mem_re;
    logic [4:0]  mem_addr;
    logic [15:0] mem_rdata = '0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
`ifdef RB_LAST_EN
    logic        out_last;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int issued = 0;
    int popped = 0;
    int n_exp = 0;
    bit stalled = 0;
    logic [15:0] held = '0;
    bit seen;
    int d0;

    rb_reader #(.ADDR_W(5), .DATA_W(16)) dut (
        .clock_i(clk), .reset_i(reset), .start_i(start), .count_i(count),
        .mem_re_o(mem_re), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .busy_o(busy), .done_o(done)
`ifdef RB_LAST_EN
        , .out_last_o(out_last)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_re) mem_rdata <= 16'h100 + {11'd0, mem_addr};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: read addresses, buffer room, beat order, stall hold, done totals.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            issued = 0; popped = 0; stalled = 0;
        end else begin
            if (start && !busy) begin
                issued = 0; popped = 0; stalled = 0;
                n_exp = (count > 6'd32) ? 32 : int'(count);
            end
            if (mem_re) begin
                check("re_room", 32'((issued - popped - int'(out_valid & out_ready)) < 2), 1);
                check("re_addr", {27'd0, mem_addr}, issued % 32);
                check("re_limit", 32'(issued < n_exp), 1);
                issued++;
            end
            if (stalled) check("stall_hold", {16'd0, out_data}, {16'd0, held});
            if (out_valid && out_ready) begin
                check("beat_data", {16'd0, out_data}, 32'h100 + popped);
                popped++;
            end
            stalled = out_valid && !out_ready;
            held = out_data;
            if (done) begin
                check("done_reads", issued, n_exp);
                check("done_beats", popped, n_exp);
                done_cnt++;
            end
        end
    end

    task automatic go(input logic [5:0] c);
        @(negedge clk); start = 1'b1; count = c; #1;
    endtask

    task automatic run(input int budget, input bit rnd, input int mid_at, output bit got);
        got = 0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            start = (c == mid_at);
            count = 6'd5;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (done) got = 1;
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_re", {31'd0, mem_re}, 0);
        check("rst_addr", {27'd0, mem_addr}, 0);
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_data", {16'd0, out_data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        @(negedge clk); reset = 1'b0;

        // Count=4 with ready held high
        d0 = done_cnt;
        go(6'd4);
        check("c4_busy_T", {31'd0, busy}, 0);
        @(negedge clk); start = 1'b0; #1;
        check("c4_re_T1", {31'd0, mem_re}, 1);
        check("c4_busy_T1", {31'd0, busy}, 1);
        check("c4_valid_T1", {31'd0, out_valid}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("c4_valid", {31'd0, out_valid}, 1);
            check("c4_data", {16'd0, out_data}, 32'h100 + i);
            check("c4_done_early", {31'd0, done}, 0);
        end
        @(negedge clk); #1;
        check("c4_done", {31'd0, done}, 1);
        check("c4_busy_fin", {31'd0, busy}, 1);
        check("c4_valid_fin", {31'd0, out_valid}, 0);
        @(negedge clk); #1;
        check("c4_busy_after", {31'd0, busy}, 0);
        check("c4_done_after", {31'd0, done}, 0);
        check("c4_done_once", done_cnt, d0 + 1);

        // Count=0, accepted right after the previous batch
        go(6'd0);
        @(negedge clk); start = 1'b0; #1;
        check("c0_done", {31'd0, done}, 1);
        check("c0_re", {31'd0, mem_re}, 0);
        check("c0_valid", {31'd0, out_valid}, 0);
        @(negedge clk); #1;
        check("c0_busy_after", {31'd0, busy}, 0);

        // Count=8 with random backpressure
        d0 = done_cnt;
        go(6'd8);
        run(200, 1, -1, seen);
        check("c8_done_seen", {31'd0, seen}, 1);
        @(negedge clk); #1;
        check("c8_done_once", done_cnt, d0 + 1);
        check("c8_beats", popped, 8);

        // Count=32 with a stray Start mid-batch
        d0 = done_cnt;
        go(6'd32);
        run(100, 0, 10, seen);
        check("c32_done_seen", {31'd0, seen}, 1);
        @(negedge clk); #1;
        check("c32_done_once", done_cnt, d0 + 1);
        check("c32_reads", issued, 32);

        // Count=40 saturates to 32
        d0 = done_cnt;
        go(6'd40);
        run(400, 1, 15, seen);
        check("c40_done_seen", {31'd0, seen}, 1);
        @(negedge clk); #1;
        check("c40_done_once", done_cnt, d0 + 1);
        check("c40_reads", issued, 32);
        check("c40_beats", popped, 32);

        // Reset on the third beat of a Count=10 batch
        d0 = done_cnt;
        go(6'd10);
        @(negedge clk); start = 1'b0;
        @(negedge clk); #1;
        check("rb_beat0", {16'd0, out_data}, 32'h100);
        @(negedge clk); #1;
        check("rb_beat1", {16'd0, out_data}, 32'h101);
        @(negedge clk); #1;
        check("rb_beat2", {16'd0, out_data}, 32'h102);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        check("rb_re", {31'd0, mem_re}, 0);
        check("rb_addr", {27'd0, mem_addr}, 0);
        check("rb_valid", {31'd0, out_valid}, 0);
        check("rb_data", {16'd0, out_data}, 0);
        check("rb_busy", {31'd0, busy}, 0);
        check("rb_done", {31'd0, done}, 0);
        repeat (3) @(negedge clk);
        #1;
        check("rb_no_done", done_cnt, d0);
        check("rb_valid_idle", {31'd0, out_valid}, 0);
        go(6'd2);
        @(negedge clk); start = 1'b0;
        @(negedge clk); #1;
        check("rb2_beat0", {16'd0, out_data}, 32'h100);
        @(negedge clk); #1;
        check("rb2_beat1", {16'd0, out_data}, 32'h101);
        @(negedge clk); #1;
        check("rb2_done", {31'd0, done}, 1);
        @(negedge clk); #1;
        check("rb2_done_once", done_cnt, d0 + 1);

`ifdef RB_LAST_EN
        // Count=3, stall on the last beat
        go(6'd3);
        @(negedge clk); start = 1'b0;
        @(negedge clk); #1;
        check("last_b0", {31'd0, out_last}, 0);
        @(negedge clk); out_ready = 1'b0; #1;
        check("last_b1", {31'd0, out_last}, 0);
        @(negedge clk); #1;
        check("last_b1_held", {31'd0, out_last}, 0);
        check("last_b1_data", {16'd0, out_data}, 32'h101);
        @(negedge clk); out_ready = 1'b1; #1;
        check("last_b1_go", {31'd0, out_last}, 0);
        @(negedge clk); out_ready = 1'b0; #1;
        check("last_b2", {31'd0, out_last}, 1);
        check("last_b2_data", {16'd0, out_data}, 32'h102);
        @(negedge clk); #1;
        check("last_b2_held", {31'd0, out_last}, 1);
        out_ready = 1'b1;
        @(negedge clk); #1;
        check("last_done", {31'd0, done}, 1);
        check("last_clear", {31'd0, out_last}, 0);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
